id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//   ID/EX pipeline register directly downstream of the register file. Captures the decoded
//   instruction fields, the register file's read_data_1/read_data_2 and ID control bits on
//   each clk edge, and hands them to the EX stage. Also detects load-use hazards (stall
//   request to PC and IF/ID), inserts bubbles on stall or branch flush, and forces $0 to read zero.
// PARAMETERS
//   DATA_W  32  datapath width
//   REG_AW  5   register address width (32 registers)
//   CTRL_W  10  control bundle width; field layout defined in pipeline_defs.vh
// PORTS
//   clk               in   1       clock, all state updates on posedge
//   reset             in   1       synchronous, active-high
//   id_valid          in   1       ID holds a real instruction
//   id_rs, id_rt, id_rd  in  REG_AW  decoded register numbers
//   id_rs_data        in   DATA_W  register file read_data_1
//   id_rt_data        in   DATA_W  register file read_data_2
//   id_imm            in   DATA_W  sign-extended immediate
//   id_ctrl           in   CTRL_W  {regWrite,memRead,memWrite,memToReg,aluSrc,regDst,aluOp[3:0]}
//   flush             in   1       branch/jump taken: squash the instruction in ID
//   wb_reg_write      in   1       WB stage writes the register file this cycle
//   wb_write_register in   REG_AW  WB destination
//   wb_write_data     in   DATA_W  WB data
//   load_use_stall    out  1       combinational: hold PC and IF/ID this cycle
//   ex_valid          out  1       registered
//   ex_rs, ex_rt, ex_rd  out  REG_AW  registered (feed forwarding unit)
//   ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered
//   ex_ctrl           out  CTRL_W  registered
// BEHAVIOUR
//   - Reset: every registered output 0 the edge after reset=1; load_use_stall therefore 0.
//     reset overrides flush, stall and bypass.
//   - Latency 1 cycle: ID values present before edge N appear on ex_* after edge N.
//   - load_use_stall = id_valid & ex_valid & ex_ctrl.memRead & (ex_rt != 0)
//       & ((ex_rt == id_rs) | (ex_rt == id_rt)). Fan-out only; this block never holds itself.
//   - Next-state select, priority: reset > (flush | load_use_stall) > capture.
//     Bubble: ex_valid=0, ex_ctrl=0, all ex_* address/data fields 0.
//     Capture with id_valid=0 also loads a bubble.
//   - $0: if id_rs==0 capture ex_rs_data=0; if id_rt==0 capture ex_rt_data=0, regardless of
//     register file contents or WB activity.
//   - A stalled instruction is recaptured the following cycle from the held IF/ID, so
//     back-to-back stalls need no internal state beyond the ID/EX register.
//   - No arithmetic; all fields pass through at full width.
// CONFIGURATION
//   WB_BYPASS_EN defined: if wb_reg_write & wb_write_register!=0 & wb_write_register==id_rs,
//     capture wb_write_data into ex_rs_data (same for rt; both may hit simultaneously).
//     Covers the register file writing on posedge while ID reads in the same cycle.
//   WB_BYPASS_EN undefined: id_rs_data/id_rt_data captured unmodified (besides $0 rule);
//     register file must then write on the falling edge.
// STRUCTURE
//   pipeline_defs.vh (shared): CTRL_W, control bit indices (CTRL_REGWRITE, CTRL_MEMREAD, ...),
//     ALU op encodings, REG_ZERO constant; also consumed by control unit and EX/MEM stage.
//   Sub-module hazard_detect: combinational load-use compare producing load_use_stall.
//   Top: bypass/$0 muxes, bubble select, single always @(posedge clk) register bank.
// TESTING
//   1 Reset: hold reset 2 cycles with id_valid=1, random id_* -> all ex_* 0, load_use_stall 0.
//   2 Pass-through: id_rs=8,id_rs_data=0x1234,id_ctrl=0x2A3 -> next cycle ex_rs=8,
//     ex_rs_data=0x1234, ex_ctrl=0x2A3, ex_valid=1.
//   3 Load-use: EX holds lw with ex_rt=9; ID add id_rs=9 -> load_use_stall=1, next ex_valid=0,
//     ex_ctrl=0; replayed add captured the cycle after; ex_rt=0 lw -> no stall.
//   4 Flush: flush=1 with valid ID -> next ex_valid=0, all ex_* 0; flush+stall -> one bubble.
//   5 $0: id_rs=0, id_rs_data=0xDEAD, wb writes reg 0 with 0xBEEF -> ex_rs_data=0.
//   6 WB_BYPASS_EN: wb_write_register=17, wb_write_data=0x55, id_rs=id_rt=17, id_rs_data=0x11
//     -> ex_rs_data=ex_rt_data=0x55; macro undefined -> both 0x11.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared ID/EX definitions: default widths, control-bundle bit positions, ALU op codes.
// Control bundle layout, MSB first: {regWrite, memRead, memWrite, memToReg, aluSrc, regDst, aluOp[3:0]}.
package id_ex_stage_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;
  localparam int DEF_CTRL_W = 10;

  localparam int CTRL_REGWRITE = 9;
  localparam int CTRL_MEMREAD  = 8;
  localparam int CTRL_MEMWRITE = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_ALUSRC   = 5;
  localparam int CTRL_REGDST   = 4;
  localparam int CTRL_ALUOP_LSB = 0;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7
  } alu_op_e;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination is a source of the instruction in ID.
module hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  output logic              load_use_stall
);

  // $0 never carries a loaded value, so a load targeting it can never be a real dependency.
  assign load_use_stall = id_valid && ex_valid && ex_mem_read && (ex_rt != '0)
                          && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, bubble insertion and $0 forcing.
// Optional macro WB_BYPASS_EN: forward the same-cycle WB write into the captured operands.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_write_register,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic              load_use_stall,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl
);

  logic              ex_valid_q,   ex_valid_d;
  logic [REG_AW-1:0] ex_rs_q,      ex_rs_d;
  logic [REG_AW-1:0] ex_rt_q,      ex_rt_d;
  logic [REG_AW-1:0] ex_rd_q,      ex_rd_d;
  logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
  logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
  logic [DATA_W-1:0] ex_imm_q,     ex_imm_d;
  logic [CTRL_W-1:0] ex_ctrl_q,    ex_ctrl_d;

  logic [DATA_W-1:0] rs_data_sel;
  logic [DATA_W-1:0] rt_data_sel;
  logic              capture;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .id_valid       (id_valid),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .ex_valid       (ex_valid_q),
    .ex_mem_read    (ex_ctrl_q[CTRL_MEMREAD]),
    .ex_rt          (ex_rt_q),
    .load_use_stall (load_use_stall)
  );

  // NOTE: every signal assigned in always_comb gets a default first so no path leaves it
  // unassigned, which is what would otherwise infer a latch.
  always_comb begin
    rs_data_sel = id_rs_data;
    rt_data_sel = id_rt_data;
`ifdef WB_BYPASS_EN
    if (wb_reg_write && (wb_write_register != '0) && (wb_write_register == id_rs))
      rs_data_sel = wb_write_data;
    if (wb_reg_write && (wb_write_register != '0) && (wb_write_register == id_rt))
      rt_data_sel = wb_write_data;
`endif
    // $0 wins over both the register file and any WB forwarding.
    if (id_rs == '0) rs_data_sel = '0;
    if (id_rt == '0) rt_data_sel = '0;
  end

`ifndef WB_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_reg_write, wb_write_register, wb_write_data};
`endif

  // A stalled or squashed slot becomes an all-zero bubble; the held IF/ID replays it later.
  assign capture = id_valid && !flush && !load_use_stall;

  always_comb begin
    ex_valid_d   = 1'b0;
    ex_rs_d      = '0;
    ex_rt_d      = '0;
    ex_rd_d      = '0;
    ex_rs_data_d = '0;
    ex_rt_data_d = '0;
    ex_imm_d     = '0;
    ex_ctrl_d    = '0;
    if (capture) begin
      ex_valid_d   = 1'b1;
      ex_rs_d      = id_rs;
      ex_rt_d      = id_rt;
      ex_rd_d      = id_rd;
      ex_rs_data_d = rs_data_sel;
      ex_rt_data_d = rt_data_sel;
      ex_imm_d     = id_imm;
      ex_ctrl_d    = id_ctrl;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q   <= 1'b0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_rd_q      <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
      ex_ctrl_q    <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_rd_q      <= ex_rd_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_imm_q     <= ex_imm_d;
      ex_ctrl_q    <= ex_ctrl_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_rs      = ex_rs_q;
  assign ex_rt      = ex_rt_q;
  assign ex_rd      = ex_rd_q;
  assign ex_rs_data = ex_rs_data_q;
  assign ex_rt_data = ex_rt_data_q;
  assign ex_imm     = ex_imm_q;
  assign ex_ctrl    = ex_ctrl_q;

endmodule
